data_memory_sized: RTL and testbench
====================================

# data_memory_sized

Parametrised, byte-addressable, big-endian data memory for the MIPS integer datapath. It adds byte, halfword and word access sizes, sign/zero extension on loads, alignment checking, a registered read port with a valid strobe, and a hardware zero-fill of the whole array after reset. It sits between the datapath's memory stage and the load/store control, in the same position as the current data memory.

## Interface
- ADDR_W, 12, byte-address width; depth = 2**ADDR_W bytes; must be ≥ 3.
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  asynchronous active-low reset.
- dm_cs  in  1  chip select; no access is performed without it.
- dm_wr  in  1  store request (qualified by dm_cs).
- dm_rd  in  1  load request (qualified by dm_cs).
- size  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- D_in  in  32  store data, right-justified for byte and halfword stores.
- D_out  out  32  registered load data.
- rd_valid  out  1  one-cycle pulse; D_out holds new load data.
- err  out  1  one-cycle pulse on a misaligned or reserved-size access.
- rdy  out  1  1 = zero-fill complete and requests are accepted.

## Operation
- **Reset values:** D_out = 0, rd_valid = 0, err = 0, rdy = 0, FSM = CLEAR, clear pointer = 0.
- **FSM states:** CLEAR and IDLE.
  - CLEAR writes 32'h0 to word `ptr` each cycle, then increments `ptr`.
  - After the last word (ptr = 2**(ADDR_W-2) - 1), the FSM moves to IDLE.
  - IDLE persists until rst_n is asserted. Asserting rst_n at any point, including mid-CLEAR, restarts CLEAR from pointer 0.
- **Requests in CLEAR** are ignored: no write, and no rd_valid or err pulse.
- **Byte order is big-endian.** A word at A maps mem[A], mem[A+1], mem[A+2], mem[A+3] to bits [31:24], [23:16], [15:8], [7:0].
  - Halfword at A: mem[A] → [15:8], mem[A+1] → [7:0].
  - Byte at A: mem[A] → [7:0].
  - Upper bits of load data are filled by sign or zero extension per sign_ext. For word loads, sign_ext is ignored.
- **Stores:**
  - Byte store writes D_in[7:0] to mem[A].
  - Halfword store writes D_in[15:8] to A and D_in[7:0] to A+1.
  - Word store writes all four bytes.
- **Alignment:** a halfword requires addr[0] = 0; a word requires addr[1:0] = 0. A misaligned or size = 11 request in IDLE:
  - performs no write;
  - leaves D_out unchanged and raises no rd_valid;
  - pulses err.
  
  Because accesses are aligned, none can run past the top address, so there is no wrap.
- **dm_wr and dm_rd together:** the write is performed, and the load returns the pre-write contents (read-before-write).
- D_out holds its value between loads.

## Timing
- **CLEAR duration:** 2**(ADDR_W-2) cycles, starting with the first rising edge after rst_n deasserts. rdy goes to 1 on the edge that completes the last clear write. Default ADDR_W gives 1024 cycles.
- **Load latency:** 1 cycle. A request sampled at edge N updates D_out and pulses rd_valid high for the cycle after edge N.
- **Store:** committed at the sampling edge. A load to the same address at edge N+1 returns the new data.
- **err timing:** registered; high for exactly the one cycle after the offending edge.
- **Throughput:** back-to-back requests are accepted every cycle while rdy = 1; there is no stall.
- **rst_n assertion:** all outputs go to their reset values immediately, without waiting for clk.

## Test plan
- **Zero-fill:** ADDR_W = 6; release rst_n → rdy rises after exactly 16 cycles; word loads at 0x00–0x3C all return 0x00000000. A store issued during CLEAR is discarded.
- **Word round-trip and byte order:**
  - sw 0x11223344 at 0x10, then lw 0x10 → 0x11223344.
  - lbu 0x11 → 0x00000022.
  - lhu 0x12 → 0x00003344.
- **Extension:**
  - sw 0x80FF7F01 at 0x20; lb 0x20 → 0xFFFFFF80; lbu 0x20 → 0x00000080.
  - lh 0x20 → 0xFFFF80FF; lh 0x22 → 0x00007F01.
- **Partial stores:** sb 0xAB at 0x21 and sh 0x1234 at 0x22 onto 0x80FF7F01 → lw 0x20 → 0x80AB1234.
- **Misalignment:**
  - lw 0x21 → err pulses for one cycle, no rd_valid, D_out unchanged.
  - sh 0x23 → err pulses, memory unchanged.
  - size = 11 → err pulses.
- **Simultaneous access and reset:**
  - wr + rd at 0x10 with D_in = 0xDEADBEEF → D_out = 0x11223344; a following lw → 0xDEADBEEF.
  - Pulse rst_n mid-CLEAR → rdy drops to 0 and a full 16-cycle CLEAR restarts.

Source files
------------

// File: rtl/data_memory_sized.sv
// Byte-addressable big-endian data memory with byte/half/word access, load extension,
// alignment checking, a registered read port and a hardware zero-fill after reset.

module dm_lane #(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);
    logic [7:0] mem [0:(2**IDX_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    // Asynchronous read: the top registers it, which gives read-before-write on same-edge stores.
    assign rdata = mem[idx];
endmodule

module data_memory_sized #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dm_cs,
    input  logic              dm_wr,
    input  logic              dm_rd,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       D_in,
    output logic [31:0]       D_out,
    output logic              rd_valid,
    output logic              err,
    output logic              rdy
);
    localparam int NUM_LANES = 4;
    localparam int IDX_W     = ADDR_W - 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {CLEAR, IDLE} state_t;

    typedef struct packed {
        logic wr;
        logic rd;
        logic err;
    } req_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    req_t             req;
    logic             misalign;
    logic             clearing;

    logic [NUM_LANES-1:0]      lane_we;
    logic [NUM_LANES-1:0][7:0] lane_wdata;
    logic [NUM_LANES-1:0][7:0] lane_rdata;
    logic [IDX_W-1:0]          lane_idx;
    logic [31:0]               ld_data;
    logic [15:0]               half;
    logic [7:0]                byte_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        case (state)
            CLEAR: begin
                ptr_n = ptr + 1'b1;
                if (ptr == {IDX_W{1'b1}}) begin
                    state_n = IDLE;
                    ptr_n   = '0;
                end
            end
            IDLE:    state_n = IDLE;
            default: state_n = CLEAR;
        endcase
    end

    assign clearing = (state == CLEAR);
    assign rdy      = (state == IDLE);

    always_comb begin
        misalign = 1'b0;
        case (size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = addr[0];
            SZ_WORD: misalign = |addr[1:0];
            default: misalign = 1'b1;
        endcase
    end

    always_comb begin
        req     = '0;
        req.wr  = rdy && dm_cs && dm_wr && !misalign;
        req.rd  = rdy && dm_cs && dm_rd && !misalign;
        req.err = rdy && dm_cs && (dm_wr || dm_rd) && misalign;
    end

    assign lane_idx = clearing ? ptr : addr[ADDR_W-1:2];

    // Lane g holds the bytes whose address ends in g; lane 0 is the most significant byte of a word.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam logic [1:0] L = 2'(g);

        always_comb begin
            lane_we[g]    = 1'b0;
            lane_wdata[g] = 8'h00;
            if (clearing) begin
                lane_we[g] = 1'b1;
            end else if (req.wr) begin
                case (size)
                    SZ_BYTE: begin
                        lane_we[g]    = (addr[1:0] == L);
                        lane_wdata[g] = D_in[7:0];
                    end
                    SZ_HALF: begin
                        lane_we[g]    = (addr[1] == L[1]);
                        lane_wdata[g] = L[0] ? D_in[7:0] : D_in[15:8];
                    end
                    SZ_WORD: begin
                        lane_we[g]    = 1'b1;
                        lane_wdata[g] = D_in[8*(NUM_LANES-1-g) +: 8];
                    end
                    default: lane_we[g] = 1'b0;
                endcase
            end
        end

        dm_lane #(.IDX_W(IDX_W)) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .idx   (lane_idx),
            .wdata (lane_wdata[g]),
            .rdata (lane_rdata[g])
        );
    end

    always_comb begin
        byte_v  = lane_rdata[addr[1:0]];
        half    = addr[1] ? {lane_rdata[2], lane_rdata[3]} : {lane_rdata[0], lane_rdata[1]};
        ld_data = 32'h0;
        case (size)
            SZ_BYTE: ld_data = {{24{sign_ext & byte_v[7]}}, byte_v};
            SZ_HALF: ld_data = {{16{sign_ext & half[15]}}, half};
            SZ_WORD: ld_data = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]};
            default: ld_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D_out    <= 32'h0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= req.rd;
            err      <= req.err;
            if (req.rd) D_out <= ld_data;
        end
    end
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized at ADDR_W = 6 (16-word zero-fill).

module tb_data_memory_sized;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dm_cs, dm_wr, dm_rd, sign_ext;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [31:0]   D_in;
    logic [31:0]   D_out;
    logic          rd_valid, err, rdy;

    int checks   = 0;
    int failures = 0;

    data_memory_sized #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dm_cs    (dm_cs),
        .dm_wr    (dm_wr),
        .dm_rd    (dm_rd),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .D_in     (D_in),
        .D_out    (D_out),
        .rd_valid (rd_valid),
        .err      (err),
        .rdy      (rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        dm_cs = 0; dm_wr = 0; dm_rd = 0; size = 2'b10; sign_ext = 0; addr = '0; D_in = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One request sampled at the next edge; outputs are observable on return.
    task automatic req(input logic wr, input logic rd, input logic [1:0] sz, input logic sx,
                       input logic [AW-1:0] a, input logic [31:0] d);
        dm_cs = 1; dm_wr = wr; dm_rd = rd; size = sz; sign_ext = sx; addr = a; D_in = d;
        tick();
        idle_in();
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic sx,
                        input logic [AW-1:0] a, input logic [31:0] exp);
        req(0, 1, sz, sx, a, 32'h0);
        chk({tag, "_vld"}, {31'b0, rd_valid}, 32'd1);
        chk(tag, D_out, exp);
    endtask

    task automatic run_clear(input string tag, input bit store_mid);
        for (int c = 1; c <= 16; c++) begin
            if (store_mid && c == 5) begin
                dm_cs = 1; dm_wr = 1; dm_rd = 1; size = 2'b10; addr = 6'h04; D_in = 32'hFFFFFFFF;
            end
            tick();
            idle_in();
            if (store_mid && c == 5) begin
                chk({tag, "_clr_vld"}, {31'b0, rd_valid}, 32'd0);
                chk({tag, "_clr_err"}, {31'b0, err}, 32'd0);
            end
            if (c == 15) chk({tag, "_rdy15"}, {31'b0, rdy}, 32'd0);
            if (c == 16) chk({tag, "_rdy16"}, {31'b0, rdy}, 32'd1);
        end
    endtask

    initial begin
        idle_in();
        rst_n = 0;
        tick(); tick();
        chk("rst_dout", D_out, 32'h0);
        chk("rst_vld", {31'b0, rd_valid}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdy", {31'b0, rdy}, 32'd0);

        rst_n = 1;
        run_clear("fill", 1'b1);
        for (int w = 0; w < 16; w++) load($sformatf("zero_%0d", w), 2'b10, 0, 6'(w * 4), 32'h0);

        req(1, 0, 2'b10, 0, 6'h10, 32'h11223344);
        chk("sw_vld", {31'b0, rd_valid}, 32'd0);
        chk("sw_err", {31'b0, err}, 32'd0);
        load("lw10", 2'b10, 0, 6'h10, 32'h11223344);
        load("lbu11", 2'b00, 0, 6'h11, 32'h00000022);
        load("lhu12", 2'b01, 0, 6'h12, 32'h00003344);

        req(1, 0, 2'b10, 0, 6'h20, 32'h80FF7F01);
        load("lb20", 2'b00, 1, 6'h20, 32'hFFFFFF80);
        load("lbu20", 2'b00, 0, 6'h20, 32'h00000080);
        load("lh20", 2'b01, 1, 6'h20, 32'hFFFF80FF);
        load("lh22", 2'b01, 1, 6'h22, 32'h00007F01);
        load("lhu20", 2'b01, 0, 6'h20, 32'h000080FF);
        load("lw20_sx", 2'b10, 1, 6'h20, 32'h80FF7F01);

        req(1, 0, 2'b00, 0, 6'h21, 32'hFFFFFFAB);
        req(1, 0, 2'b01, 0, 6'h22, 32'hFFFF1234);
        load("partial", 2'b10, 0, 6'h20, 32'h80AB1234);

        req(0, 1, 2'b10, 0, 6'h21, 32'h0);
        chk("mis_lw_err", {31'b0, err}, 32'd1);
        chk("mis_lw_vld", {31'b0, rd_valid}, 32'd0);
        chk("mis_lw_dout", D_out, 32'h80AB1234);
        tick();
        chk("mis_lw_err_end", {31'b0, err}, 32'd0);
        req(1, 0, 2'b01, 0, 6'h23, 32'h0000BEEF);
        chk("mis_sh_err", {31'b0, err}, 32'd1);
        load("mis_sh_mem", 2'b10, 0, 6'h20, 32'h80AB1234);
        chk("mis_sh_err_end", {31'b0, err}, 32'd0);
        req(0, 1, 2'b11, 0, 6'h20, 32'h0);
        chk("sz11_err", {31'b0, err}, 32'd1);
        chk("sz11_vld", {31'b0, rd_valid}, 32'd0);

        req(1, 1, 2'b10, 0, 6'h10, 32'hDEADBEEF);
        chk("rbw_vld", {31'b0, rd_valid}, 32'd1);
        chk("rbw_old", D_out, 32'h11223344);
        load("rbw_new", 2'b10, 0, 6'h10, 32'hDEADBEEF);

        rst_n = 0; #1;
        chk("async_rdy", {31'b0, rdy}, 32'd0);
        chk("async_dout", D_out, 32'h0);
        tick();
        rst_n = 1;
        for (int c = 0; c < 8; c++) tick();
        chk("mid_rdy", {31'b0, rdy}, 32'd0);
        rst_n = 0;
        tick();
        chk("mid_rst_rdy", {31'b0, rdy}, 32'd0);
        rst_n = 1;
        run_clear("refill", 1'b0);
        load("refill_lw10", 2'b10, 0, 6'h10, 32'h0);
        load("refill_lw20", 2'b10, 0, 6'h20, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
